// File: rtl/btn_event.sv
// Per-button press / long-press / auto-repeat event generator.
// Each button runs its own FSM; all events merge into one valid/ready stream.
module btn_event #(
   parameter int N             = 5,
   parameter int CNT_WIDTH     = 24,
   parameter int HOLD_CYCLES   = 10_000_000,
   parameter int REPEAT_CYCLES = 2_500_000,
   localparam int IW           = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  level,
   output logic [N-1:0]  press,
   output logic [N-1:0]  repeat_p,
   output logic [N-1:0]  release_p,
   output logic [N-1:0]  held,
   output logic          ev_valid,
   input  logic          ev_ready,
   output logic [IW-1:0] ev_code,
   output logic [1:0]    ev_kind,
   output logic          ev_overflow
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PRESSED = 2'd1,
      S_HELD    = 2'd2
   } state_e;

   localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] REP_LAST  = CNT_WIDTH'(REPEAT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

   state_e               state_q [N];
   state_e               state_d [N];
   logic [CNT_WIDTH-1:0] timer_q [N];
   logic [CNT_WIDTH-1:0] timer_d [N];

   logic [N-1:0] prs_q, prs_d;
   logic [N-1:0] rep_q, rep_d;
   logic [N-1:0] rel_q, rel_d;
   logic [N-1:0] pp_q, pp_d;
   logic [N-1:0] pr_q, pr_d;
   logic [N-1:0] pl_q, pl_d;
   logic         ovf_q, ovf_d;

   logic [N-1:0]  any_pend;
   logic [N-1:0]  sel_oh;
   logic [IW-1:0] sel_idx;
   logic [1:0]    sel_kind;
   logic          sel_found;
   logic          accept;
   logic [N-1:0]  clr_pp, clr_pr, clr_pl;
   logic [N-1:0]  lost;

   // Per-button state machines
   always_comb begin
      prs_d = '0;
      rep_d = '0;
      rel_d = '0;
      for (int i = 0; i < N; i++) begin
         state_d[i] = state_q[i];
         timer_d[i] = timer_q[i];
         unique case (state_q[i])
            S_IDLE: begin
               if (level[i]) begin
                  state_d[i] = S_PRESSED;
                  timer_d[i] = '0;
                  prs_d[i]   = 1'b1;
               end
            end
            S_PRESSED: begin
               if (!level[i]) begin
                  state_d[i] = S_IDLE;
                  timer_d[i] = '0;
                  rel_d[i]   = 1'b1;
               end else if (timer_q[i] == HOLD_LAST) begin
                  state_d[i] = S_HELD;
                  timer_d[i] = '0;
                  rep_d[i]   = 1'b1;
               end else begin
                  timer_d[i] = timer_q[i] + CNT_ONE;
               end
            end
            S_HELD: begin
               if (!level[i]) begin
                  state_d[i] = S_IDLE;
                  timer_d[i] = '0;
                  rel_d[i]   = 1'b1;
               end else if (timer_q[i] == REP_LAST) begin
                  timer_d[i] = '0;
                  rep_d[i]   = 1'b1;
               end else begin
                  timer_d[i] = timer_q[i] + CNT_ONE;
               end
            end
            default: begin
               state_d[i] = S_IDLE;
               timer_d[i] = '0;
            end
         endcase
      end
   end

   // Lowest index wins; within a button press > repeat > release
   always_comb begin
      any_pend  = pp_q | pr_q | pl_q;
      sel_oh    = '0;
      sel_idx   = '0;
      sel_kind  = 2'b00;
      sel_found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!sel_found && any_pend[i]) begin
            sel_found = 1'b1;
            sel_oh[i] = 1'b1;
            sel_idx   = IW'(i);
            if (pp_q[i])      sel_kind = 2'b01;
            else if (pr_q[i]) sel_kind = 2'b10;
            else              sel_kind = 2'b11;
         end
      end
   end

   always_comb begin
      accept = sel_found & ev_ready;
      clr_pp = sel_oh & {N{accept && sel_kind == 2'b01}};
      clr_pr = sel_oh & {N{accept && sel_kind == 2'b10}};
      clr_pl = sel_oh & {N{accept && sel_kind == 2'b11}};
      lost   = (prs_d & pp_q & ~clr_pp)
             | (rep_d & pr_q & ~clr_pr)
             | (rel_d & pl_q & ~clr_pl);
      // A set on the accepted bit wins, keeping the fresh event
      pp_d   = (pp_q & ~clr_pp) | prs_d;
      pr_d   = (pr_q & ~clr_pr) | rep_d;
      pl_d   = (pl_q & ~clr_pl) | rel_d;
      ovf_d  = ovf_q | (|lost);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            state_q[i] <= S_IDLE;
            timer_q[i] <= '0;
         end
         prs_q <= '0;
         rep_q <= '0;
         rel_q <= '0;
         pp_q  <= '0;
         pr_q  <= '0;
         pl_q  <= '0;
         ovf_q <= 1'b0;
      end else begin
         for (int i = 0; i < N; i++) begin
            state_q[i] <= state_d[i];
            timer_q[i] <= timer_d[i];
         end
         prs_q <= prs_d;
         rep_q <= rep_d;
         rel_q <= rel_d;
         pp_q  <= pp_d;
         pr_q  <= pr_d;
         pl_q  <= pl_d;
         ovf_q <= ovf_d;
      end
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         held[i] = (state_q[i] == S_HELD);
      end
   end

   assign press       = prs_q;
   assign repeat_p    = rep_q;
   assign release_p   = rel_q;
   assign ev_valid    = sel_found;
   assign ev_code     = sel_idx;
   assign ev_kind     = sel_kind;
   assign ev_overflow = ovf_q;

endmodule

// File: tb/tb_btn_event.sv
// Randomized scoreboard bench for btn_event against an elapsed-time model.
module tb_btn_event;

   localparam int N    = 5;
   localparam int CW   = 8;
   localparam int HOLD = 8;
   localparam int REP  = 4;
   localparam int IW   = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  level;
   logic [N-1:0]  press, repeat_p, release_p, held;
   logic          ev_valid, ev_ready, ev_overflow;
   logic [IW-1:0] ev_code;
   logic [1:0]    ev_kind;

   always #5 clk = ~clk;

   btn_event #(
      .N(N), .CNT_WIDTH(CW), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
   ) dut (
      .clk(clk), .rst(rst), .level(level),
      .press(press), .repeat_p(repeat_p), .release_p(release_p),
      .held(held), .ev_valid(ev_valid), .ev_ready(ev_ready),
      .ev_code(ev_code), .ev_kind(ev_kind), .ev_overflow(ev_overflow)
   );

   typedef struct packed {
      logic [N-1:0]  prs;
      logic [N-1:0]  rep;
      logic [N-1:0]  rel;
      logic [N-1:0]  hld;
      logic          vld;
      logic [IW-1:0] code;
      logic [1:0]    kind;
      logic          ovf;
   } exp_t;

   exp_t expq[$];

   int n_vec  = 0;
   int n_miss = 0;
   bit running = 0;

   // Reference model: press time per button plus a set of pending kinds
   bit           act   [N];
   int           start [N];
   bit   [3:1]   pend  [N];
   bit           m_ovf;
   int           edge_no;
   logic [N-1:0] m_prs, m_rep, m_rel;

   function automatic int pick_idx();
      for (int i = 0; i < N; i++)
         if (pend[i] != 3'b000) return i;
      return -1;
   endfunction

   function automatic int pick_kind(input int i);
      if (pend[i][1]) return 1;
      if (pend[i][2]) return 2;
      return 3;
   endfunction

   function automatic void model_edge(input logic [N-1:0] lv,
                                      input logic rdy, input logic r);
      int si, el, ev;
      edge_no++;
      m_prs = '0;
      m_rep = '0;
      m_rel = '0;
      if (r) begin
         for (int i = 0; i < N; i++) begin
            act[i]  = 0;
            pend[i] = '0;
         end
         m_ovf = 0;
         return;
      end
      si = pick_idx();
      if (si >= 0 && rdy) pend[si][pick_kind(si)] = 1'b0;
      for (int i = 0; i < N; i++) begin
         ev = 0;
         if (!act[i]) begin
            if (lv[i]) begin
               ev = 1;
               act[i] = 1;
               start[i] = edge_no;
            end
         end else if (!lv[i]) begin
            ev = 3;
            act[i] = 0;
         end else begin
            el = edge_no - start[i];
            if (el == HOLD || (el > HOLD && (el - HOLD) % REP == 0)) ev = 2;
         end
         if (ev != 0) begin
            if (pend[i][ev]) m_ovf = 1;
            pend[i][ev] = 1'b1;
            if (ev == 1) m_prs[i] = 1'b1;
            if (ev == 2) m_rep[i] = 1'b1;
            if (ev == 3) m_rel[i] = 1'b1;
         end
      end
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      int si;
      e = '0;
      e.prs = m_prs;
      e.rep = m_rep;
      e.rel = m_rel;
      for (int i = 0; i < N; i++)
         e.hld[i] = act[i] && (edge_no - start[i] >= HOLD);
      si = pick_idx();
      if (si >= 0) begin
         e.vld  = 1'b1;
         e.code = IW'(si);
         e.kind = 2'(pick_kind(si));
      end
      e.ovf = m_ovf;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act_v,
                      input logic [15:0] exp_v);
      n_vec++;
      if (act_v !== exp_v) begin
         n_miss++;
         $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, act_v, exp_v);
      end
   endtask

   // Monitor: one expected entry per cycle, compared mid-cycle
   always @(negedge clk) begin
      exp_t e;
      if (running) begin
         if (expq.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL queue_empty t=%0t got=0 exp=1", $time);
         end else begin
            e = expq.pop_front();
            chk("press",    16'(press),       16'(e.prs));
            chk("repeat",   16'(repeat_p),    16'(e.rep));
            chk("release",  16'(release_p),   16'(e.rel));
            chk("held",     16'(held),        16'(e.hld));
            chk("ev_valid", 16'(ev_valid),    16'(e.vld));
            chk("ev_code",  16'(ev_code),     16'(e.code));
            chk("ev_kind",  16'(ev_kind),     16'(e.kind));
            chk("overflow", 16'(ev_overflow), 16'(e.ovf));
         end
      end
   end

   task automatic apply(input logic [N-1:0] lv, input logic rdy,
                        input logic r);
      level    = lv;
      ev_ready = rdy;
      rst      = r;
      @(posedge clk);
      #1;
      model_edge(lv, rdy, r);
      expq.push_back(model_out());
      running = 1;
   endtask

   task automatic hold(input logic [N-1:0] lv, input logic rdy,
                       input int n);
      for (int k = 0; k < n; k++) apply(lv, rdy, 1'b0);
   endtask

   initial begin
      logic [N-1:0] lv;
      logic         rdy;
      int           bp;
      rst = 1'b1;
      level = '0;
      ev_ready = 1'b0;
      edge_no = 0;
      m_ovf = 0;
      for (int i = 0; i < N; i++) begin
         act[i] = 0;
         start[i] = 0;
         pend[i] = '0;
      end
      apply('0, 1'b0, 1'b1);
      apply('0, 1'b0, 1'b1);
      hold('0, 1'b1, 2);
      // short press, long press, simultaneous presses
      hold(5'b00100, 1'b1, 3);
      hold('0, 1'b1, 6);
      hold(5'b00001, 1'b1, 20);
      hold('0, 1'b1, 6);
      hold(5'b10010, 1'b1, 3);
      hold('0, 1'b1, 6);
      // backpressure: press, release, press with no consumer
      hold(5'b01000, 1'b0, 1);
      hold('0, 1'b0, 1);
      hold(5'b01000, 1'b0, 1);
      hold('0, 1'b0, 2);
      hold('0, 1'b1, 6);
      apply('0, 1'b1, 1'b1);
      // old repeat accepted on the edge a new repeat arrives
      hold(5'b00010, 1'b1, 2);
      hold(5'b00010, 1'b0, 10);
      hold(5'b00010, 1'b1, 6);
      hold('0, 1'b1, 4);
      // reset mid-hold with the level kept high
      hold(5'b00100, 1'b1, 12);
      apply(5'b00100, 1'b1, 1'b1);
      apply(5'b00100, 1'b1, 1'b1);
      hold(5'b00100, 1'b1, 3);
      hold('0, 1'b1, 4);
      // random traffic with bursts of backpressure and rare resets
      lv = '0;
      bp = 0;
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 9) == 0) lv[i] = ~lv[i];
         if (bp > 0) bp--;
         else if ($urandom_range(0, 49) == 0) bp = $urandom_range(3, 25);
         rdy = (bp == 0) && ($urandom_range(0, 3) != 0);
         apply(lv, rdy, 1'b0);
         if ($urandom_range(0, 399) == 0) apply(lv, rdy, 1'b1);
      end
      hold('0, 1'b1, 10);
      @(negedge clk);
      #1;
      running = 0;
      n_vec++;
      if (expq.size() != 0) begin
         n_miss++;
         $display("FAIL drain got=%0d exp=0", expq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
